elementwise_div: RTL and testbench
==================================

# elementwise_div

Sequential elementwise divider for 4x4 matrices. It reverses the datapath's elementwise multiply stage: it takes 16 packed 2W-bit dividends (product-width elements) and 16 packed W-bit divisors, and returns 16 W-bit quotients and remainders. All lanes run in parallel as radix-2 restoring dividers under one shared FSM, with valid/ready handshakes on input and output.

## Interface
- W, 8, element width; dividend lanes are 2W bits, divisor/quotient/remainder lanes are W bits.
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- i_valid  in  1  operand set valid.
- o_ready  out  1  block can accept operands (high only in IDLE).
- i_mtx_m  in  16*2W  dividends; lane k at [k*2W +: 2W].
- i_mtx_v  in  16*W  divisors; lane k at [k*W +: W].
- o_valid  out  1  results valid.
- i_ready  in  1  downstream accepts results.
- o_mtx_q  out  16*W  quotients; lane k at [k*W +: W].
- o_mtx_r  out  16*W  remainders; lane k at [k*W +: W].
- o_div0  out  16  bit k set when divisor k == 0.
- o_ovf  out  16  bit k set when the true quotient k > 2^W-1 (see Configuration).

## Operation
- FSM has three states: IDLE, RUN and DONE.
- **IDLE:**
  - o_ready=1.
  - On i_valid&&o_ready: latch both operand vectors, clear per-lane partial remainder (W+1 bits) and quotient (2W bits), set counter=0, go to RUN.
- **RUN:** one restoring step per cycle per lane.
  - Shift the next dividend MSB into the partial remainder.
  - Trial-subtract the divisor; keep the difference if it is non-negative.
  - Shift the quotient bit in.
  - The counter runs 0..2W-1. At count 2W-1, go to DONE.
  - i_valid is ignored; o_ready=0.
- **DONE:**
  - o_valid=1; o_mtx_q, o_mtx_r, o_div0 and o_ovf are held stable.
  - On i_ready, go to IDLE. With i_ready low, stay in DONE indefinitely.
- **Per-lane result:**
  - Remainder is always < divisor, so it fits in W bits.
  - Full quotient is 2W bits; the W-bit output rule is in Configuration.
- **Divisor 0:**
  - q = 2^W-1, r = dividend[W-1:0], o_div0[k]=1, o_ovf[k]=0.
  - Other lanes are unaffected.
- Arithmetic is unsigned only.
- Outputs are registered and change only on the DONE entry edge and on reset.
- **Reset** (any state, including mid-RUN):
  - State=IDLE, counter=0.
  - o_valid=0, o_ready=1 after reset release.
  - o_mtx_q, o_mtx_r, o_div0 and o_ovf all = 0.
  - The in-flight operation is discarded.

## Timing
- Operand accept edge = cycle 0.
- o_valid rises after edge 2W (16 cycles for W=8).
- The output transfer occurs on the edge where o_valid&&i_ready.
- o_ready returns high the cycle after the transfer.
- Minimum issue interval is 2W+2 cycles.
- There is no combinational path from i_ready to o_ready or from i_valid to any output.

## Configuration
- Macro: ELEMDIV_SAT_EN.
- **Defined:**
  - A quotient exceeding 2^W-1 saturates to 2^W-1 and sets o_ovf[k].
  - Remainder is still the true remainder.
- **Undefined:**
  - Quotient output is the low W bits of the 2W-bit quotient.
  - o_ovf is tied to 0.
- Divide-by-zero behaviour is identical in both builds.

## Test plan
- **Basic divide (W=8):** all lanes 100/7, plus lane 5 = 255/255.
  - All lanes except 5: q=14, r=2.
  - Lane 5: q=1, r=0.
  - o_valid rises exactly 16 cycles after accept.
- **Overflow:** lane 3 = 60000/3.
  - ELEMDIV_SAT_EN defined: q=255, r=0, o_ovf[3]=1.
  - Undefined: q=32, r=0, o_ovf=0.
- **Divide by zero:** lane 9 = 1234/0, other lanes 50/5.
  - Lane 9: q=255, r=210, o_div0=16'h0200.
  - Other lanes: q=10, r=0.
- **Backpressure:** hold i_ready low for 5 cycles in DONE.
  - Outputs and o_valid stay stable; o_ready stays 0.
  - Transfer occurs on the first i_ready high; o_ready=1 the next cycle.
- **Ignored input:** pulse i_valid with different operands during RUN.
  - Results match the first operand set.
  - The second set is not accepted until IDLE.
- **Reset mid-operation:** assert rstn low at RUN cycle 7.
  - o_valid=0, outputs 0, o_ready=1 after release.
  - A fresh 100/7 then completes correctly in 16 cycles.

Source files
------------

// File: rtl/elementwise_div_if.sv
// Operand/result bundle for elementwise_div: operand handshake in, result handshake out.
// The divider sits on the slave modport; the producer/consumer side uses master.
interface elementwise_div_if #(
  parameter int W = 8
);
  logic              i_valid;
  logic              o_ready;
  logic [16*2*W-1:0] i_mtx_m;
  logic [16*W-1:0]   i_mtx_v;
  logic              o_valid;
  logic              i_ready;
  logic [16*W-1:0]   o_mtx_q;
  logic [16*W-1:0]   o_mtx_r;
  logic [15:0]       o_div0;
  logic [15:0]       o_ovf;

  modport slave (
    input  i_valid, i_mtx_m, i_mtx_v, i_ready,
    output o_ready, o_valid, o_mtx_q, o_mtx_r, o_div0, o_ovf
  );

  modport master (
    output i_valid, i_mtx_m, i_mtx_v, i_ready,
    input  o_ready, o_valid, o_mtx_q, o_mtx_r, o_div0, o_ovf
  );
endinterface

// File: rtl/elementwise_div.sv
// 16-lane unsigned restoring divider (2W/W -> W quotient, W remainder), one shared FSM.
// Optional ELEMDIV_SAT_EN: saturate oversized quotients and flag them on o_ovf.
module elementwise_div #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  elementwise_div_if.slave    bus,
  output logic [1:0]          state_dbg
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // o_ready and o_valid are decoded from the state register only.
  localparam int N  = 16;
  localparam int DW = 2 * W;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  bit_idx;
  logic           accept;
  logic           last;

  logic [DW-1:0]  m_q     [N];
  logic [W-1:0]   v_q     [N];
  logic [W-1:0]   rem     [N];
  logic [DW-1:0]  quo     [N];
  logic [W:0]     shifted [N];
  logic [W:0]     sub     [N];
  logic           ge      [N];
  logic [W-1:0]   rem_nxt [N];
  logic [DW-1:0]  quo_nxt [N];

  logic [N*W-1:0] q_reg;
  logic [N*W-1:0] r_reg;
  logic [N-1:0]   div0_reg;
  logic [N-1:0]   ovf_reg;

  assign accept    = bus.i_valid && (state == IDLE);
  assign last      = (state == RUN) && (cnt == CW'(DW - 1));
  assign bit_idx   = CW'(DW - 1) - cnt;
  assign state_dbg = state;

  assign bus.o_ready = (state == IDLE);
  assign bus.o_valid = (state == DONE);
  assign bus.o_mtx_q = q_reg;
  assign bus.o_mtx_r = r_reg;
  assign bus.o_div0  = div0_reg;
  assign bus.o_ovf   = ovf_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (bus.i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step per lane: bring in the next dividend bit MSB-first, keep the
  // difference only when the trial subtraction does not go negative.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      shifted[k] = {rem[k], m_q[k][bit_idx]};
      ge[k]      = (shifted[k] >= {1'b0, v_q[k]});
      sub[k]     = shifted[k] - {1'b0, v_q[k]};
      rem_nxt[k] = W'(ge[k] ? sub[k] : shifted[k]);
      quo_nxt[k] = DW'({quo[k], ge[k]});
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      div0_reg <= '0;
      ovf_reg  <= '0;
      for (int k = 0; k < N; k++) begin
        m_q[k] <= '0;
        v_q[k] <= '0;
        rem[k] <= '0;
        quo[k] <= '0;
      end
    end else begin
      if (accept) begin
        cnt <= '0;
        for (int k = 0; k < N; k++) begin
          m_q[k] <= bus.i_mtx_m[k*DW +: DW];
          v_q[k] <= bus.i_mtx_v[k*W +: W];
          rem[k] <= '0;
          quo[k] <= '0;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        for (int k = 0; k < N; k++) begin
          rem[k] <= rem_nxt[k];
          quo[k] <= quo_nxt[k];
        end
      end

      // Results are captured from the final step's combinational values on DONE entry.
      if (last) begin
        for (int k = 0; k < N; k++) begin
          if (v_q[k] == '0) begin
            q_reg[k*W +: W] <= '1;
            r_reg[k*W +: W] <= m_q[k][W-1:0];
            div0_reg[k]     <= 1'b1;
            ovf_reg[k]      <= 1'b0;
          end else begin
            r_reg[k*W +: W] <= rem_nxt[k];
            div0_reg[k]     <= 1'b0;
`ifdef ELEMDIV_SAT_EN
            if (|quo_nxt[k][DW-1:W]) begin
              q_reg[k*W +: W] <= '1;
              ovf_reg[k]      <= 1'b1;
            end else begin
              q_reg[k*W +: W] <= quo_nxt[k][W-1:0];
              ovf_reg[k]      <= 1'b0;
            end
`else
            q_reg[k*W +: W] <= quo_nxt[k][W-1:0];
            ovf_reg[k]      <= 1'b0;
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_elementwise_div.sv
// Directed bench for elementwise_div (W=8) with a scoreboard of expected result sets.
module tb_elementwise_div;
  localparam int W = 8;

  typedef struct packed {
    logic [127:0] q;
    logic [127:0] r;
    logic [15:0]  div0;
    logic [15:0]  ovf;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [1:0] state_dbg;
  int         cyc;
  int         acc_cyc;
  int         n_assert;
  int         n_fail;
  exp_t       exp_q[$];

  elementwise_div_if #(.W(W)) bus ();

  elementwise_div #(.W(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [255:0] m, input logic [127:0] v);
    exp_t        e;
    logic [15:0] mk;
    logic [15:0] vk;
    logic [15:0] qf;
    e = '0;
    for (int k = 0; k < 16; k++) begin
      mk = m[k*16 +: 16];
      vk = {8'h00, v[k*8 +: 8]};
      if (vk == 16'd0) begin
        e.q[k*8 +: 8] = 8'hFF;
        e.r[k*8 +: 8] = mk[7:0];
        e.div0[k]     = 1'b1;
      end else begin
        qf            = mk / vk;
        e.r[k*8 +: 8] = 8'(mk % vk);
`ifdef ELEMDIV_SAT_EN
        if (qf > 16'd255) begin
          e.q[k*8 +: 8] = 8'hFF;
          e.ovf[k]      = 1'b1;
        end else begin
          e.q[k*8 +: 8] = qf[7:0];
        end
`else
        e.q[k*8 +: 8] = qf[7:0];
`endif
      end
    end
    return e;
  endfunction

  // driver: wait for o_ready, present operands for one accept edge
  task automatic send(input logic [255:0] m, input logic [127:0] v);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.o_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", bus.o_ready, 1'b1);
    bus.i_mtx_m = m;
    bus.i_mtx_v = v;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    exp_q.push_back(model(m, v));
    bus.i_valid = 1'b0;
  endtask

  // monitor: wait for o_valid, hold i_ready low for `hold` cycles, then transfer
  task automatic collect(input string tag, input int hold);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!bus.o_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_valid) begin
      check({tag, "_valid_timeout"}, 1'b0, 1'b1);
      return;
    end
    check({tag, "_latency"}, 256'(cyc - acc_cyc), 256'd16);
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_result"}, 1'b1, 1'b0);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check({tag, "_q"}, bus.o_mtx_q, e.q);
      check({tag, "_r"}, bus.o_mtx_r, e.r);
      check({tag, "_div0"}, bus.o_div0, e.div0);
      check({tag, "_ovf"}, bus.o_ovf, e.ovf);
      check({tag, "_valid_held"}, bus.o_valid, 1'b1);
      check({tag, "_ready_low"}, bus.o_ready, 1'b0);
      if (i < hold) @(negedge clk);
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_dropped"}, bus.o_valid, 1'b0);
    check({tag, "_ready_back"}, bus.o_ready, 1'b1);
  endtask

  initial begin
    logic [255:0] m;
    logic [127:0] v;
    cyc         = 0;
    n_assert    = 0;
    n_fail      = 0;
    rstn        = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_mtx_m = '0;
    bus.i_mtx_v = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_ready", bus.o_ready, 1'b1);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_q", bus.o_mtx_q, 128'd0);
    check("rst_r", bus.o_mtx_r, 128'd0);
    check("rst_div0", bus.o_div0, 16'd0);
    check("rst_ovf", bus.o_ovf, 16'd0);

    // basic divide: 100/7 everywhere, lane 5 = 255/255
    m = {16{16'd100}};
    v = {16{8'd7}};
    m[5*16 +: 16] = 16'd255;
    v[5*8 +: 8]   = 8'd255;
    send(m, v);
    collect("basic", 0);

    // overflow: lane 3 = 60000/3
    m = {16{16'd100}};
    v = {16{8'd7}};
    m[3*16 +: 16] = 16'd60000;
    v[3*8 +: 8]   = 8'd3;
    send(m, v);
    collect("ovf", 0);

    // divide by zero on lane 9, combined with 5 cycles of backpressure
    m = {16{16'd50}};
    v = {16{8'd5}};
    m[9*16 +: 16] = 16'd1234;
    v[9*8 +: 8]   = 8'd0;
    send(m, v);
    collect("div0_bp", 5);

    // random lanes
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 16; k++) begin
        m[k*16 +: 16] = 16'($urandom_range(0, 65535));
        v[k*8 +: 8]   = 8'($urandom_range(0, 255));
      end
      send(m, v);
      collect("rand", $urandom_range(0, 2));
    end

    // ignored input: second operand set pulsed during RUN
    m = {16{16'd1000}};
    v = {16{8'd9}};
    send(m, v);
    repeat (3) @(negedge clk);
    bus.i_mtx_m = {16{16'd77}};
    bus.i_mtx_v = {16{8'd2}};
    bus.i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ign_ready_low", bus.o_ready, 1'b0);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    collect("ignored", 0);
    repeat (2) @(negedge clk);
    check("ign_no_accept", bus.o_valid, 1'b0);
    check("ign_idle", state_dbg, 2'd0);

    // reset mid-operation at RUN cycle 7
    m = {16{16'd100}};
    v = {16{8'd7}};
    send(m, v);
    repeat (7) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", bus.o_valid, 1'b0);
    check("mid_rst_q", bus.o_mtx_q, 128'd0);
    check("mid_rst_r", bus.o_mtx_r, 128'd0);
    check("mid_rst_div0", bus.o_div0, 16'd0);
    check("mid_rst_ovf", bus.o_ovf, 16'd0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", bus.o_ready, 1'b1);
    check("mid_rst_valid_after", bus.o_valid, 1'b0);
    send(m, v);
    collect("after_rst", 0);

    check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
